// File: rtl/cdc_bits_sync.sv
// cdc_bits_sync: independent per-bit flop chains that carry quasi-static bits into the clk_out domain.
// Optional CDC_BITS_SYNC_CHANGE_EN macro adds a registered one-cycle bits_changed pulse output.
module cdc_bits_sync #(
  parameter int unsigned         NUM_BITS    = 1,
  parameter int unsigned         NUM_STAGES  = 2,
  parameter logic [NUM_BITS-1:0] RESET_VALUE = {NUM_BITS{1'b0}}
) (
  input  logic                clk_out,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] bits_in,
`ifdef CDC_BITS_SYNC_CHANGE_EN
  output logic                bits_changed,
`endif
  output logic [NUM_BITS-1:0] bits_out
);

  generate
    if (NUM_STAGES < 2) begin : gen_bad_stages
      $error("cdc_bits_sync: NUM_STAGES must be at least 2");
    end
    if (NUM_STAGES > 8) begin : gen_bad_stages_hi
      $error("cdc_bits_sync: NUM_STAGES must be at most 8");
    end
    if (NUM_BITS < 1 || NUM_BITS > 256) begin : gen_bad_bits
      $error("cdc_bits_sync: NUM_BITS must be in 1..256");
    end
  endgenerate

  // One chain per bit; no logic ever crosses between chains.
  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : gen_bit
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE" *)
    logic [NUM_STAGES-1:0] stage_reg;

    for (genvar si = 0; si < NUM_STAGES; si++) begin : gen_stage
      if (si == 0) begin : gen_first
        always_ff @(posedge clk_out or posedge reset) begin
          if (reset) begin
            stage_reg[si] <= RESET_VALUE[gi];
          end else begin
            stage_reg[si] <= bits_in[gi];
          end
        end
      end else begin : gen_next
        always_ff @(posedge clk_out or posedge reset) begin
          if (reset) begin
            stage_reg[si] <= RESET_VALUE[gi];
          end else begin
            stage_reg[si] <= stage_reg[si-1];
          end
        end
      end
    end

    assign bits_out[gi] = stage_reg[NUM_STAGES-1];
  end

`ifdef CDC_BITS_SYNC_CHANGE_EN
  // History holds the previous bits_out, so the pulse lands one cycle after the output moves.
  logic [NUM_BITS-1:0] hist_reg;
  logic                changed_reg;

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      hist_reg    <= RESET_VALUE;
      changed_reg <= 1'b0;
    end else begin
      hist_reg    <= bits_out;
      changed_reg <= (bits_out != hist_reg);
    end
  end

  assign bits_changed = changed_reg;
`endif

endmodule

// File: tb/tb_cdc_bits_sync.sv
// Scoreboard bench for cdc_bits_sync: three instances (2-bit/2-stage, 2-bit/4-stage, 8-bit/2-stage).
module tb_cdc_bits_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] in2, out2, in4, out4;
  logic [7:0] in8, out8;
  logic       chg2, chg4, chg8;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  logic [1:0] q2[$];
  logic [1:0] q4[$];
  logic [7:0] q8[$];
  // Expected bits_out after the previous two edges, for the change-pulse model.
  logic [1:0] p2a, p2b, p4a, p4b;
  logic [7:0] p8a, p8b;

  cdc_bits_sync #(.NUM_BITS(2), .NUM_STAGES(2), .RESET_VALUE(2'b00)) dut2 (
    .clk_out(clk), .reset(reset), .bits_in(in2),
`ifdef CDC_BITS_SYNC_CHANGE_EN
    .bits_changed(chg2),
`endif
    .bits_out(out2)
  );

  cdc_bits_sync #(.NUM_BITS(2), .NUM_STAGES(4), .RESET_VALUE(2'b10)) dut4 (
    .clk_out(clk), .reset(reset), .bits_in(in4),
`ifdef CDC_BITS_SYNC_CHANGE_EN
    .bits_changed(chg4),
`endif
    .bits_out(out4)
  );

  cdc_bits_sync #(.NUM_BITS(8), .NUM_STAGES(2), .RESET_VALUE(8'h00)) dut8 (
    .clk_out(clk), .reset(reset), .bits_in(in8),
`ifdef CDC_BITS_SYNC_CHANGE_EN
    .bits_changed(chg8),
`endif
    .bits_out(out8)
  );

`ifndef CDC_BITS_SYNC_CHANGE_EN
  assign chg2 = 1'b0;
  assign chg4 = 1'b0;
  assign chg8 = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out2"}, 32'(out2), 32'h0);
    check_eq({tag, "_out4"}, 32'(out4), 32'h2);
    check_eq({tag, "_out8"}, 32'(out8), 32'h0);
`ifdef CDC_BITS_SYNC_CHANGE_EN
    check_eq({tag, "_chg2"}, 32'(chg2), 32'h0);
    check_eq({tag, "_chg4"}, 32'(chg4), 32'h0);
    check_eq({tag, "_chg8"}, 32'(chg8), 32'h0);
`endif
  endtask

  // Called while reset is low and before the first sampling edge: the chain
  // shows RESET_VALUE for NUM_STAGES-1 edges, then the currently held input.
  task automatic restart_scoreboard();
    q2.delete(); q4.delete(); q8.delete();
    q2.push_back(2'b00);
    repeat (3) q4.push_back(2'b10);
    q8.push_back(8'h00);
    q2.push_back(in2);
    q4.push_back(in4);
    q8.push_back(in8);
    p2a = 2'b00; p2b = 2'b00;
    p4a = 2'b10; p4b = 2'b10;
    p8a = 8'h00; p8b = 8'h00;
  endtask

  task automatic step(input logic [1:0] v2, input logic [1:0] v4, input logic [7:0] v8);
    logic [1:0] e2, e4;
    logic [7:0] e8;
    @(posedge clk);
    #1;
    in2 = v2; in4 = v4; in8 = v8;
    q2.push_back(v2); q4.push_back(v4); q8.push_back(v8);
    @(negedge clk);
    e2 = q2.pop_front();
    e4 = q4.pop_front();
    e8 = q8.pop_front();
    txn++;
    $display("txn %0d: in2=%0h in4=%0h in8=%02h | out2=%0h/%0h out4=%0h/%0h out8=%02h/%02h chg=%0b%0b%0b",
             txn, v2, v4, v8, out2, e2, out4, e4, out8, e8, chg2, chg4, chg8);
    check_eq("out2", 32'(out2), 32'(e2));
    check_eq("out4", 32'(out4), 32'(e4));
    check_eq("out8", 32'(out8), 32'(e8));
`ifdef CDC_BITS_SYNC_CHANGE_EN
    check_eq("chg2", 32'(chg2), 32'(p2a != p2b));
    check_eq("chg4", 32'(chg4), 32'(p4a != p4b));
    check_eq("chg8", 32'(chg8), 32'(p8a != p8b));
`endif
    p2b = p2a; p2a = e2;
    p4b = p4a; p4a = e4;
    p8b = p8a; p8a = e8;
  endtask

  logic [1:0] tab2 [8];
  logic [7:0] tab8 [8];

  initial begin
    tab2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    tab8 = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h3C, 8'hFF, 8'h00, 8'h81};

    // Reset held with clocks running and all-ones style inputs.
    reset = 1'b1;
    in2 = 2'b11; in4 = 2'b01; in8 = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      check_reset_state("reset_hold");
    end

    // Release with counter start value and depth-test start value presented.
    @(negedge clk);
    reset = 1'b0;
    in2 = 2'd0; in4 = 2'b10; in8 = 8'hA5;
    restart_scoreboard();

    for (int i = 0; i < 8; i++) step(tab2[i], 2'b01, tab8[i]);

    for (int i = 0; i < 12; i++)
      step(2'($urandom_range(3)), 2'($urandom_range(3)), 8'($urandom_range(255)));

    for (int i = 0; i < 6; i++) step(2'd3, 2'b01, 8'hC3);

    // Asynchronous reset between edges must clear outputs before the next edge.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    reset = 1'b0;
    restart_scoreboard();

    for (int i = 0; i < 14; i++) step(2'd3, 2'b01, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
